arcabuco_muldiv_sequencer: RTL and testbench

Multicycle sequencer for the RV32M multiply/divide operations of the arcabuco execution stage. It accepts one operation at a time from the execute-stage control over a valid/ready handshake, and runs an iterative shift-add multiply or restoring divide. While busy it stalls the pipeline, and it holds the result until the writeback side accepts it. It replaces the single-cycle path that the execution unit enables with `muldiv_en`.

---
 rtl/arcabuco_muldiv_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_arcabuco_muldiv_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arcabuco_muldiv_sequencer.sv
// Multicycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide.
// Define ARCABUCO_MULDIV_FASTPATH_EN to finish divide-by-zero, overflow and zero multiplies in PREP.
module arcabuco_muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                dbz_q, dbz_d;
  logic                ovf_q, ovf_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand conditioning; a_q/b_q hold the raw operands while in PREP.
  logic            is_div;
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            dbz_det, ovf_det;

  always_comb begin
    is_div   = op_q[2];
    a_signed = (op_q == OpMulh) || (op_q == OpMulhsu) || (op_q == OpDiv) || (op_q == OpRem);
    b_signed = (op_q == OpMulh) || (op_q == OpDiv) || (op_q == OpRem);
    sign_a   = a_signed && a_q[XLEN-1];
    sign_b   = b_signed && b_q[XLEN-1];
    a_abs    = sign_a ? -a_q : a_q;
    b_abs    = sign_b ? -b_q : b_q;
    dbz_det  = is_div && (b_q == '0);
    ovf_det  = ((op_q == OpDiv) || (op_q == OpRem)) && (a_q == MinNeg) && (b_q == '1);
  end

  // One iteration of each algorithm. Multiply shifts the multiplier out of b_q;
  // divide shifts the dividend out of a_q into the partial remainder.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_acc;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       div_diff;
  logic                q_bit;
  logic [XLEN-1:0]     rem_new;
  logic [2*XLEN-1:0]   div_acc;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : {XLEN{1'b0}})};
    mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, b_q};
    q_bit    = ~div_diff[XLEN];
    rem_new  = q_bit ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_acc  = {rem_new, acc_q[XLEN-2:0], q_bit};
  end

  // Sign correction and result selection for FIX.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quo_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OpMul:                     fix_result = prod_s[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_result = prod_s[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_result = dbz_q ? '1 : (ovf_q ? MinNeg : quo_s);
      default:                   fix_result = ovf_q ? '0 : rem_s;
    endcase
  end

`ifdef ARCABUCO_MULDIV_FASTPATH_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;

  // op_q[1] separates rem/remu from div/divu.
  always_comb begin
    fast_hit    = 1'b0;
    fast_result = '0;
    if (!is_div && ((a_q == '0) || (b_q == '0))) begin
      fast_hit = 1'b1;
    end else if (dbz_det) begin
      fast_hit    = 1'b1;
      fast_result = op_q[1] ? a_q : '1;
    end else if (ovf_det) begin
      fast_hit    = 1'b1;
      fast_result = op_q[1] ? '0 : a_q;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (op_valid && !kill) begin
          state_d = StPrep;
          op_d    = op_code;
          a_d     = op_a;
          b_d     = op_b;
        end
      end
      StPrep: begin
        a_d     = a_abs;
        b_d     = b_abs;
        neg_d   = (is_div && op_q[1]) ? sign_a : (sign_a ^ sign_b);
        dbz_d   = dbz_det;
        ovf_d   = ovf_det;
        acc_d   = '0;
        cnt_d   = CntW'(XLEN - 1);
        state_d = StCalc;
`ifdef ARCABUCO_MULDIV_FASTPATH_EN
        if (fast_hit) begin
          state_d  = StDone;
          result_d = fast_result;
        end
`endif
      end
      StCalc: begin
        if (is_div) begin
          acc_d = div_acc;
          a_d   = a_q << 1;
        end else begin
          acc_d = mul_acc;
          b_d   = b_q >> 1;
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        result_d = fix_result;
        state_d  = StDone;
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything; result stays untouched so it only moves on DONE entry.
    if (kill && (state_q != StIdle)) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign op_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_arcabuco_muldiv_sequencer.sv
// Randomized and directed bench for arcabuco_muldiv_sequencer against an arithmetic model.
module tb_arcabuco_muldiv_sequencer;

  logic        clock;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  arcabuco_muldiv_sequencer #(.XLEN(32)) dut (
    .clock     (clock),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .kill      (kill),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef ARCABUCO_MULDIV_FASTPATH_EN
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (!op[2] && (a == 0 || b == 0)) return 2;
`endif
    return 35;
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!op_ready && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    chk("ready_before_op", op_ready, 1);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    @(posedge clock); #1;
    op_valid = 1'b0;
  endtask

  // Returns the cycle index (accept edge = 0) of the first res_valid.
  task automatic wait_result(output int lat, output logic busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (!res_valid && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    chk("idle_after_ack", op_ready, 1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int   lat;
    logic bok;
    start_op(op, a, b);
    wait_result(lat, bok);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_latency"}, lat, exp_lat(op, a, b));
    chk({tag, "_busy"}, bok, 1);
    handshake();
  endtask

  logic [2:0]  plan_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
                                 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] plan_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                                 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd5, 32'd5,
                                 32'h8000_0000, 32'h8000_0000};
  logic [31:0] plan_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd7,
                                 32'd7, 32'd7, 32'd7, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] plan_r  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(7, 0))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(15, 0));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic        bok;
    logic        stable;
    logic        saw_valid;
    logic [31:0] r0;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst       = 1'b0;
    op_valid  = 1'b0;
    op_code   = '0;
    op_a      = '0;
    op_b      = '0;
    kill      = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_op_ready", op_ready, 1);
    #3 rst = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("plan%0d", i), plan_op[i], plan_a[i], plan_b[i], plan_r[i]);
    end

    // Back-pressure: result held for 10 cycles, then next op accepted right after IDLE.
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_result(lat, bok);
    r0     = result;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      if (result !== r0 || !res_valid || op_ready) stable = 1'b0;
    end
    chk("bp_result", r0, 32'hFFFF_FFEB);
    chk("bp_stable", stable, 1);
    handshake();
    do_op("bp_next", 3'd5, 32'd100, 32'd7, 32'd14);

    // Kill during CALC at cycle T+10.
    start_op(3'd0, 32'd5, 32'd6);
    saw_valid = 1'b0;
    repeat (9) begin
      if (res_valid) saw_valid = 1'b1;
      @(posedge clock); #1;
    end
    kill = 1'b1;
    @(posedge clock); #1;
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    chk("kill_op_ready", op_ready, 1);
    repeat (40) begin
      if (res_valid) saw_valid = 1'b1;
      @(posedge clock); #1;
    end
    chk("kill_no_res_valid", saw_valid, 0);
    do_op("after_kill", 3'd5, 32'd9, 32'd3, 32'd3);

    // Asynchronous reset mid-CALC.
    start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (8) begin @(posedge clock); #1; end
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_op_ready", op_ready, 1);
    #3 rst = 1'b1;
    @(posedge clock); #1;
    do_op("after_rst", 3'd0, 32'd3, 32'd4, 32'd12);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(7, 0));
      a  = rand_operand();
      b  = rand_operand();
      do_op($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
